// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial LSB-first a-b subtractor; SERIAL_SUBTRACTOR_OVF_EN adds the ovf flag
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic             r_bin;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_accept;
    logic             w_run;
    logic             w_last;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_work_nxt;

    // One bit-slice of a full subtractor working on the current LSBs.
    assign w_d        = r_a[0] ^ r_b[0] ^ r_bin;
    assign w_bout     = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_bin);
    assign w_work_nxt = {w_d, r_work[WIDTH-1:1]};

    assign w_accept = (r_state == S_IDLE) && start;
    assign w_run    = (r_state == S_RUN);
    assign w_last   = w_run && (r_cnt == LAST_BIT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status outputs; DONE always falls back to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (r_cnt == LAST_BIT) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand shift registers, borrow flop, working register and bit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_work <= '0;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_work <= '0;
            r_bin  <= 1'b0;
            r_cnt  <= '0;
        end else if (w_run) begin
            r_a    <= {1'b0, r_a[WIDTH-1:1]};
            r_b    <= {1'b0, r_b[WIDTH-1:1]};
            r_work <= w_work_nxt;
            r_bin  <= w_bout;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Result registers update only on the final bit so partial sums never leak out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_last) begin
            r_diff   <= w_work_nxt;
            r_borrow <= w_bout;
        end
    end

    assign diff   = r_diff;
    assign borrow = r_borrow;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic [1:0] r_msb;
    logic       r_ovf;

    // Operand sign bits are shifted out during RUN, so keep a copy from accept time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_msb <= 2'b00;
        end else if (w_accept) begin
            r_msb <= {a[WIDTH-1], b[WIDTH-1]};
        end
    end

    // Signed overflow: operand signs differ and the result sign differs from the minuend.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= (r_msb[1] ^ r_msb[0]) & (w_d ^ r_msb[1]);
        end
    end

    assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor at WIDTH=8 and WIDTH=3
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start8 = 1'b0;
    logic       start3 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic [2:0] a3 = '0, b3 = '0, diff3;
    logic       busy8, done8, borrow8;
    logic       busy3, done3, borrow3;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       ovf8, ovf3;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Expected entries: {ovf, borrow, diff zero-extended to 8 bits}.
    logic [9:0] q8[$];
    logic [9:0] q3[$];

    logic pd8 = 1'b0;
    logic pd3 = 1'b0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(8)) u_dut8 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start8),
        .a      (a8),
        .b      (b8),
        .busy   (busy8),
        .done   (done8),
        .diff   (diff8),
        .borrow (borrow8)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf8)
`endif
    );

    serial_subtractor #(.WIDTH(3)) u_dut3 (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start3),
        .a      (a3),
        .b      (b3),
        .busy   (busy3),
        .done   (done3),
        .diff   (diff3),
        .borrow (borrow3)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        ,
        .ovf    (ovf3)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic logic [9:0] model(input int w, input int av, input int bv);
        int   m;
        int   d;
        int   sa;
        int   sb;
        int   sd;
        logic ov;
        logic [7:0] d8;
        m  = (1 << w) - 1;
        d  = (av - bv) & m;
        sa = (av >= (1 << (w - 1))) ? av - (1 << w) : av;
        sb = (bv >= (1 << (w - 1))) ? bv - (1 << w) : bv;
        sd = sa - sb;
        ov = (sd > m / 2) || (sd < -(m / 2) - 1);
        d8 = 8'(d);
        return {ov, (av < bv), d8};
    endfunction

    // Monitor for the 8-bit instance.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                fail_now("dut8_unexpected_done");
            end else begin
                e = q8.pop_front();
                chk("dut8_diff", 32'(diff8), 32'(e[7:0]));
                chk("dut8_borrow", 32'(borrow8), 32'(e[8]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("dut8_ovf", 32'(ovf8), 32'(e[9]));
`endif
            end
            chk("dut8_done_one_cycle", 32'(pd8), 32'(0));
        end
        pd8 = rst_n & done8;
    end

    // Monitor for the 3-bit instance.
    always @(negedge clk) begin
        logic [9:0] e;
        if (rst_n && done3) begin
            if (q3.size() == 0) begin
                fail_now("dut3_unexpected_done");
            end else begin
                e = q3.pop_front();
                chk("dut3_diff", 32'(diff3), 32'(e[2:0]));
                chk("dut3_borrow", 32'(borrow3), 32'(e[8]));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                chk("dut3_ovf", 32'(ovf3), 32'(e[9]));
`endif
            end
            chk("dut3_done_one_cycle", 32'(pd3), 32'(0));
        end
        pd3 = rst_n & done3;
    end

    // Issue one operation from an IDLE negedge; returns on the first IDLE negedge after done.
    // inj pulses start with junk operands mid-RUN and in the DONE cycle (8-bit only).
    task automatic op(input bit s, input int av, input int bv, input bit inj);
        int nb;
        int cyc;
        int w;
        w = s ? 3 : 8;
        if (s) begin
            start3 = 1'b1; a3 = 3'(av); b3 = 3'(bv);
            q3.push_back(model(3, av, bv));
        end else begin
            start8 = 1'b1; a8 = 8'(av); b8 = 8'(bv);
            q8.push_back(model(8, av, bv));
        end
        @(negedge clk);
        start8 = 1'b0; start3 = 1'b0;
        a8 = 8'($urandom); b8 = 8'($urandom);
        a3 = 3'($urandom); b3 = 3'($urandom);
        nb = 0;
        cyc = 0;
        while (!(s ? done3 : done8) && cyc < 40) begin
            if (s ? busy3 : busy8) nb++;
            if (inj && cyc == 2) begin
                start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
            end else if (inj && cyc == 3) begin
                start8 = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        if (cyc >= 40) begin
            fail_now("done_timeout");
        end
        chk("busy_cycles", 32'(nb), 32'(w));
        chk("busy_low_in_done", 32'(s ? busy3 : busy8), 32'(0));
        if (inj) begin
            start8 = 1'b1; a8 = 8'($urandom); b8 = 8'($urandom);
        end
        @(negedge clk);
        start8 = 1'b0;
        chk("done_falls", 32'(s ? done3 : done8), 32'(0));
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy8), 32'(0));
        chk("rst_done", 32'(done8), 32'(0));
        chk("rst_diff", 32'(diff8), 32'(0));
        chk("rst_borrow", 32'(borrow8), 32'(0));
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("rst_ovf", 32'(ovf8), 32'(0));
`endif
        rst_n = 1'b1;
        @(negedge clk);

        op(0, 8'h5A, 8'h3C, 0);
        op(0, 8'h10, 8'h20, 0);
        op(0, 8'hFF, 8'hFF, 0);
        op(0, 8'h80, 8'h01, 0);
        op(0, 8'h7F, 8'hFF, 0);
        op(0, 8'h05, 8'h03, 0);
        op(0, 8'hC3, 8'h42, 1);
        op(0, 8'h00, 8'h01, 0);
        for (int i = 0; i < 20; i++) begin
            op(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0);
        end

        // Reset in the middle of RUN: everything clears at once, no done pulse.
        op(0, 8'h20, 8'h01, 0);
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h11;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy8), 32'(0));
        chk("midrst_done", 32'(done8), 32'(0));
        chk("midrst_diff", 32'(diff8), 32'(0));
        chk("midrst_borrow", 32'(borrow8), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("midrst_no_done", 32'(done8), 32'(0));
        end
        op(0, 8'h03, 8'h05, 0);

        for (int x = 0; x < 8; x++) begin
            for (int y = 0; y < 8; y++) begin
                op(1, x, y, 0);
            end
        end

        repeat (3) @(negedge clk);
        chk("q8_drained", 32'(q8.size()), 32'(0));
        chk("q3_drained", 32'(q3.size()), 32'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time limit so the bench can never hang.
    initial begin
        #200000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
